mux_nto1_pipe: RTL and testbench
================================

Name: mux_nto1_pipe

Overview:
- Parametrised N-input, W-bit-per-channel selector with a registered, valid/ready-handshaked output stage.
- Next generation of the team's 8:1 gate-level single-bit mux: generalised channel count and data width, and adds pipelining, backpressure and out-of-range select detection.
- Sits between ALU result sources and the writeback/forwarding path, so operand selection no longer sits on a combinational critical path.

Parameters:
- N, 8, number of input channels (2..64, need not be a power of 2)
- W, 1, data width per channel in bits (1..64)
- SELW, clog2(N), select width (derived; not overridden by users)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  N*W  flattened channels; channel k occupies bits [k*W+W-1 : k*W]
- in_sel  input  SELW  channel index; value 0 selects channel 0 (the old i1)
- in_valid  input  1  in_data/in_sel are valid this cycle
- in_ready  output  1  block can accept a transfer this cycle
- out_data  output  W  selected channel data, registered
- out_sel  output  SELW  in_sel that produced out_data
- out_err  output  1  out_data came from an out-of-range in_sel
- out_valid  output  1  out_data/out_sel/out_err are valid
- out_ready  input  1  downstream accepts the output this cycle

Behaviour:
- Reset (async assert, sync deassert by the integrator): out_data=0, out_sel=0, out_err=0, out_valid=0. in_ready=1 in the first cycle after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready at a rising edge.
- Selection:
  - On input transfer, register out_data = channel[in_sel] and out_sel = in_sel.
  - Latency is 1 cycle: out_valid rises the edge after the input transfer.
- Out of range (in_sel >= N, only possible when N is not a power of 2):
  - The transfer is still accepted.
  - out_data=0, out_err=1 for that beat.
  - out_err is per-beat, not sticky.
- Base stage (macro absent):
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Simultaneous input and output transfer replaces the register contents; out_valid stays 1. Full throughput, 1 beat/cycle.
  - Output transfer with no input transfer clears out_valid. out_data holds its last value; it is don't-care while invalid.
- Stall: while out_valid && !out_ready, out_data, out_sel and out_err stay stable, with no change on in_data toggles.
- in_data/in_sel are ignored when in_valid=0 or in_ready=0.
- Reset mid-operation drops any held beat. No partial output is visible after reset.

Optional Feature:
- Macro MUX_SKID_EN.
- Defined:
  - Adds a 2-entry skid buffer (main + skid register) and breaks the combinational out_ready -> in_ready path.
  - in_ready is a flop, = skid entry empty.
  - If a beat arrives while main is full and out_ready=0, it goes to skid.
  - On the next output transfer, skid moves to main.
  - Order is preserved. Full throughput is sustained. Worst-case occupancy is 2.
  - Reset empties both entries; in_ready=1.
- Undefined: base single-stage behaviour above.
- Latency is 1 cycle in both builds when unstalled.

Decomposition:
- Shared package/include mux_pkg:
  - clog2 constant function
  - SELW derivation
  - MUX_MAX_N=64 limit check, which triggers an elaboration error if N>64, N<2 or W<1
- Sub-module mux_sel_comb:
  - Purely combinational N:1 W-bit selector plus range check.
  - Outputs sel_data and sel_err; unit-tested alone.
- mux_nto1_pipe instantiates mux_sel_comb once, plus the handshake registers.

Test Plan (N=8, W=4 unless stated):
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_err=0 immediately (async); in_ready=1 the cycle after release.
- Basic select: in_data=0x76543210, in_sel=5, in_valid=1, out_ready=1 -> next cycle out_data=0x5, out_sel=5, out_valid=1, out_err=0.
- Back-to-back: sel sequence 0..7, one per cycle, out_ready=1 -> outputs 0x0..0x7 on consecutive cycles, in_ready never drops.
- Backpressure: out_ready=0 for 3 cycles with in_sel=2 held, then in_data changed -> out_data holds 0x2; base build in_ready=0; MUX_SKID_EN build accepts exactly one more beat, then in_ready=0; on release, beats emerge in order.
- Out of range: N=6, W=8, in_sel=7 -> out_data=0x00, out_err=1; the next beat with in_sel=3 gives out_err=0.
- Random soak: random in_valid/out_ready with a scoreboard, both macro settings -> no loss, no duplication, in-order delivery, data equal to channel[sel].

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 pipelined selector family.
package mux_pkg;

    localparam int unsigned MUX_MAX_N = 64;
    localparam int unsigned MUX_MAX_W = 64;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // A select port is never narrower than one bit, even for degenerate N.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    function automatic bit params_ok(input int unsigned n, input int unsigned w);
        return (n >= 2) && (n <= MUX_MAX_N) && (w >= 1) && (w <= MUX_MAX_W);
    endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N:1 W-bit selector with out-of-range select detection.
module mux_sel_comb
    import mux_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1,
    localparam int unsigned SELW = sel_width(N)
) (
    input  logic [N*W-1:0]  in_data,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    sel_data,
    output logic            sel_err
);

    // Unmatched (out-of-range) selects fall through to zero data.
    always_comb begin
        sel_data = '0;
        sel_err  = (32'(sel) >= N);
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SELW'(k)) sel_data = in_data[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N:1 selector with valid/ready handshake on both sides.
// Define MUX_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1,
    localparam int unsigned SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [SELW-1:0] in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready
);

    if (!params_ok(N, W)) begin : g_param_check
        $error("mux_nto1_pipe: N must be 2..%0d and W 1..%0d", MUX_MAX_N, MUX_MAX_W);
    end

    logic [W-1:0]    sel_data;
    logic            sel_err;
    logic            in_fire;
    logic            out_fire;

    logic            valid_q, valid_d;
    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            err_q, err_d;

    mux_sel_comb #(
        .N(N),
        .W(W)
    ) u_sel (
        .in_data (in_data),
        .sel     (in_sel),
        .sel_data(sel_data),
        .sel_err (sel_err)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

`ifdef MUX_SKID_EN
    logic            skid_valid_q, skid_valid_d;
    logic [W-1:0]    skid_data_q, skid_data_d;
    logic [SELW-1:0] skid_sel_q, skid_sel_d;
    logic            skid_err_q, skid_err_d;

    assign in_ready = !skid_valid_q;

    // A beat lands in skid only when main is full and not draining;
    // skid always refills main first, so ordering is preserved.
    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        sel_d        = sel_q;
        err_d        = err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        skid_err_d   = skid_err_q;
        if (skid_valid_q) begin
            if (out_fire) begin
                data_d       = skid_data_q;
                sel_d        = skid_sel_q;
                err_d        = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!valid_q || out_fire) begin
                valid_d = 1'b1;
                data_d  = sel_data;
                sel_d   = in_sel;
                err_d   = sel_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_data;
                skid_sel_d   = in_sel;
                skid_err_d   = sel_err;
            end
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
            skid_err_q   <= skid_err_d;
        end
    end
`else
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
        if (in_fire) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            sel_d   = in_sel;
            err_d   = sel_err;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: an N=8/W=4 and an N=6/W=8 instance
// driven with shared control; honours MUX_SKID_EN for stall expectations.
module tb_mux_nto1_pipe;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] sel;
        logic       err;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_sel;
    logic        out_ready;

    logic [31:0] in_data8;
    logic        in_ready8;
    logic [3:0]  out_data8;
    logic [2:0]  out_sel8;
    logic        out_err8;
    logic        out_valid8;

    logic [47:0] in_data6;
    logic        in_ready6;
    logic [7:0]  out_data6;
    logic [2:0]  out_sel6;
    logic        out_err6;
    logic        out_valid6;

    beat_t       q8[$];
    beat_t       q6[$];
    int          tests_run;
    int          tests_failed;

    mux_nto1_pipe #(.N(8), .W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_data(in_data8), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready8),
        .out_data(out_data8), .out_sel(out_sel8), .out_err(out_err8),
        .out_valid(out_valid8), .out_ready(out_ready)
    );

    mux_nto1_pipe #(.N(6), .W(8)) dut6 (
        .clk(clk), .rst(rst),
        .in_data(in_data6), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready6),
        .out_data(out_data6), .out_sel(out_sel6), .out_err(out_err6),
        .out_valid(out_valid6), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, then score the transfers the
    // coming posedge will perform.
    task automatic step(input logic iv, input logic [2:0] sel, input logic [31:0] d8,
                        input logic [47:0] d6, input logic ordy);
        beat_t e;
        @(negedge clk);
        in_valid  = iv;
        in_sel    = sel;
        in_data8  = d8;
        in_data6  = d6;
        out_ready = ordy;
        #1;
        if (out_valid8 && out_ready) begin
            if (q8.size() == 0) check("q8_underflow", 1, 0);
            else begin
                e = q8.pop_front();
                check("d8", 64'(out_data8), 64'(e.data));
                check("s8", 64'(out_sel8), 64'(e.sel));
                check("e8", 64'(out_err8), 64'(e.err));
            end
        end
        if (out_valid6 && out_ready) begin
            if (q6.size() == 0) check("q6_underflow", 1, 0);
            else begin
                e = q6.pop_front();
                check("d6", 64'(out_data6), 64'(e.data));
                check("s6", 64'(out_sel6), 64'(e.sel));
                check("e6", 64'(out_err6), 64'(e.err));
            end
        end
        if (in_valid && in_ready8) begin
            e.data = {4'h0, d8[int'(sel)*4 +: 4]};
            e.sel  = sel;
            e.err  = 1'b0;
            q8.push_back(e);
        end
        if (in_valid && in_ready6) begin
            e.data = (sel < 3'd6) ? d6[int'(sel)*8 +: 8] : 8'h00;
            e.sel  = sel;
            e.err  = (sel >= 3'd6);
            q6.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q8.size() == 0 && q6.size() == 0 && !out_valid8 && !out_valid6) break;
            step(1'b0, 3'd0, 32'h0, 48'h0, 1'b1);
        end
        check("drain_empty", 64'(q8.size() + q6.size()), 0);
        check("drain_valid", 64'({out_valid8, out_valid6}), 0);
    endtask

    localparam logic [31:0] D8A = 32'h7654_3210;
    localparam logic [31:0] D8B = 32'hFEDC_BA98;
    localparam logic [47:0] D6A = 48'hA5A4_A3A2_A1A0;
`ifdef MUX_SKID_EN
    localparam logic EXP_STALL_RDY = 1'b1;
    localparam int   EXP_STALL_CNT = 2;
`else
    localparam logic EXP_STALL_RDY = 1'b0;
    localparam int   EXP_STALL_CNT = 1;
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data8  = '0;
        in_data6  = '0;
        out_ready = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid8), 0);
        check("rst_data", 64'(out_data8), 0);
        check("rst_sel", 64'(out_sel8), 0);
        check("rst_err", 64'(out_err6), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3'd0, 32'h0, 48'h0, 1'b0);
        check("rst_rdy", 64'(in_ready8), 1);

        // Basic select
        step(1'b1, 3'd5, D8A, D6A, 1'b1);
        step(1'b0, 3'd0, D8A, D6A, 1'b1);
        check("basic_valid", 64'(out_valid8), 1);
        check("basic_data", 64'(out_data8), 64'h5);
        check("basic_sel", 64'(out_sel8), 5);
        check("basic_err", 64'(out_err8), 0);
        drain();

        // Back-to-back, sel 0..7 (6 and 7 are out of range for the N=6 instance)
        for (int s = 0; s < 8; s++) begin
            step(1'b1, 3'(s), D8A, D6A, 1'b1);
            check("b2b_rdy", 64'(in_ready8), 1);
        end
        drain();

        // Backpressure
        step(1'b1, 3'd2, D8A, D6A, 1'b0);
        check("bp_rdy0", 64'(in_ready8), 1);
        step(1'b1, 3'd2, D8A, D6A, 1'b0);
        check("bp_rdy1", 64'(in_ready8), 64'(EXP_STALL_RDY));
        check("bp_hold1", 64'(out_data8), 64'h2);
        step(1'b1, 3'd2, D8A, D6A, 1'b0);
        check("bp_rdy2", 64'(in_ready8), 0);
        step(1'b1, 3'd2, D8B, D6A, 1'b0);
        check("bp_rdy3", 64'(in_ready8), 0);
        check("bp_hold3", 64'(out_data8), 64'h2);
        check("bp_sel3", 64'(out_sel8), 2);
        check("bp_accepted", 64'(q8.size()), 64'(EXP_STALL_CNT));
        drain();

        // Out of range on N=6
        step(1'b1, 3'd7, D8A, D6A, 1'b1);
        step(1'b1, 3'd3, D8A, D6A, 1'b1);
        check("oor_data", 64'(out_data6), 0);
        check("oor_err", 64'(out_err6), 1);
        step(1'b0, 3'd0, D8A, D6A, 1'b1);
        check("oor_next_err", 64'(out_err6), 0);
        check("oor_next_data", 64'(out_data6), 64'hA3);
        drain();

        // Random soak
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                 {16'($urandom), 32'($urandom)}, ($urandom % 4) != 0);
        end
        drain();

        // Reset mid-stream with a held out-of-range beat
        step(1'b1, 3'd7, D8B, D6A, 1'b0);
        step(1'b0, 3'd0, D8B, D6A, 1'b0);
        check("mid_pre_valid", 64'(out_valid6), 1);
        rst = 1'b1;
        #1;
        check("mid_valid8", 64'(out_valid8), 0);
        check("mid_data8", 64'(out_data8), 0);
        check("mid_valid6", 64'(out_valid6), 0);
        check("mid_err6", 64'(out_err6), 0);
        q8.delete();
        q6.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3'd0, 32'h0, 48'h0, 1'b0);
        check("mid_rdy", 64'(in_ready8), 1);
        check("mid_after_valid", 64'(out_valid8), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
